time_entry_loader: RTL and testbench
====================================

Name: time_entry_loader

Overview:
- Keypad-side writer for the MM:SS countdown timer chain. Collects BCD digits from the keypad encoder, shifting each new digit in from the right (microwave style: 1,2,3 gives 01:23).
- On start, validates the entry and drives the timer's digit buses plus a registered, glitch-free active-low load strobe.
- Locks out keypad entry while the timer runs. Unlocks on timer_done or cancel.

Parameters:
- MAX_DIGITS, 4, number of BCD digits held (MM:SS); fixed at 4 for this release.
- SEC_TENS_MAX, 5, largest legal seconds-tens digit at start.
- LOAD_CYCLES, 1, number of clock cycles loadn is held low (1..4).

Ports:
- clock  in  1  system clock, rising edge.
- clrn  in  1  asynchronous active-low reset.
- key_valid  in  1  one-cycle strobe: key_digit is valid.
- key_digit  in  4  BCD digit from keypad encoder.
- start  in  1  one-cycle start-key strobe.
- cancel  in  1  one-cycle cancel/clear-key strobe.
- timer_done  in  1  level from timer chain: all counters zero while running.
- min_tens  out  4  data to minutes-tens counter.
- min_ones  out  4  data to minutes-ones counter.
- sec_tens  out  4  data to seconds-tens counter.
- sec_ones  out  4  data to seconds-ones counter.
- loadn  out  1  active-low load strobe to all four counters, registered.
- timer_en  out  1  count enable to timer chain; high only in RUN.
- digit_count  out  3  digits entered so far (0..4).
- entry_error  out  1  one-cycle pulse on rejected start.

Behaviour:
- Reset (clrn low, async): state IDLE, all digit outputs 0, digit_count 0, loadn 1, timer_en 0, entry_error 0.
- States:
  - IDLE: no digits entered.
  - ENTRY: 1..4 digits held.
  - LOAD: loadn low for LOAD_CYCLES.
  - RUN: timer counting.
- Digit shift on an accepted key:
  - min_tens <= min_ones, min_ones <= sec_tens, sec_tens <= sec_ones, sec_ones <= key_digit.
  - digit_count increments, saturating at 4.
  - Visible on the next rising edge (1-cycle latency).
- A key is accepted only in IDLE or ENTRY, and only when key_digit <= 9 and digit_count < 4.
  - Codes above 9 are ignored.
  - A fifth digit is ignored; the buffer does not roll over.
- IDLE -> ENTRY on the first accepted key.
- ENTRY + start:
  - sec_tens > SEC_TENS_MAX: entry_error high for exactly 1 cycle, stay in ENTRY, digits kept.
  - All four digits zero: entry_error pulse, stay in ENTRY.
  - Otherwise: go to LOAD.
- IDLE + start: ignored, no error.
- LOAD:
  - loadn driven 0 from the register for LOAD_CYCLES cycles.
  - Digit outputs are stable for the whole window and for 1 cycle before it.
  - Then RUN with loadn 1 and timer_en 1.
- RUN:
  - Keys and start are ignored.
  - timer_done high -> IDLE with timer_en 0, digits cleared to 0, digit_count 0.
- cancel in any state: next edge gives IDLE, digits 0, digit_count 0, loadn 1, timer_en 0. A LOAD in progress is aborted.
- Simultaneous strobes, same cycle: cancel > start > key_valid. The lower-priority strobes are dropped, not queued.
- timer_done outside RUN is ignored.
- Async reset mid-LOAD: loadn returns to 1 immediately, with no partial-load glitch generated by this block.
- All outputs are registered; no combinational path from inputs to loadn.

Decomposition:
- Shared package timer_pkg:
  - state encoding constants IDLE/ENTRY/LOAD/RUN;
  - BCD_MAX = 9;
  - SEC_TENS_MAX;
  - the 4-bit BCD digit width.
- Sub-module bcd_shift4: 4-digit left-shifting BCD register with clear and saturating count. The FSM stays in time_entry_loader.

Test Plan:
- Reset, then keys 1,2,3, then start -> digits 0,1,2,3; digit_count 3; loadn low exactly 1 cycle; then timer_en 1.
- Keys 9,9,9,9,8 -> fifth key ignored; digits 9,9,9,9; start -> entry_error pulse (sec_tens 9 > 5), state ENTRY, timer_en 0.
- Key 0 then start -> entry_error pulse; then key 0xA -> ignored, digits unchanged.
- Keys 4,5 then start; in RUN apply key 7 and start -> ignored; timer_done high -> IDLE, all digits 0, timer_en 0.
- Same cycle key_valid = 1, start = 1, cancel = 1 while in ENTRY with 1,2 -> IDLE, digits cleared, no loadn pulse, no error.
- LOAD_CYCLES = 3, clrn asserted during the second low cycle -> loadn 1 and all outputs 0 immediately; after release, state IDLE.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the MM:SS countdown timer chain: state encoding,
// BCD limits and digit width.
package timer_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX      = 4'd9;
    localparam logic [DIGIT_W-1:0] SEC_TENS_MAX = 4'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        LOAD  = 2'd2,
        RUN   = 2'd3
    } state_t;

endpackage

// File: rtl/bcd_shift4.sv
// Four-digit BCD entry register: new digits enter on the right and push the
// older ones left, with a synchronous clear and a saturating digit count.
module bcd_shift4 #(
    parameter int MAX_DIGITS = 4
) (
    input  logic                         clock,
    input  logic                         clrn,
    input  logic                         clear,
    input  logic                         shift,
    input  logic [timer_pkg::DIGIT_W-1:0] digit_in,
    output logic [timer_pkg::DIGIT_W-1:0] d3,
    output logic [timer_pkg::DIGIT_W-1:0] d2,
    output logic [timer_pkg::DIGIT_W-1:0] d1,
    output logic [timer_pkg::DIGIT_W-1:0] d0,
    output logic [2:0]                   count
);
    import timer_pkg::*;

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            d3    <= '0;
            d2    <= '0;
            d1    <= '0;
            d0    <= '0;
            count <= '0;
        end else if (clear) begin
            d3    <= '0;
            d2    <= '0;
            d1    <= '0;
            d0    <= '0;
            count <= '0;
        end else if (shift) begin
            d3 <= d2;
            d2 <= d1;
            d1 <= d0;
            d0 <= digit_in;
            // Saturate so a full buffer never wraps its count back to zero.
            if (count < 3'(MAX_DIGITS))
                count <= count + 3'd1;
        end
    end

endmodule

// File: rtl/time_entry_loader.sv
// Keypad-side writer for the MM:SS timer: collects digits, validates them on
// start, issues a registered active-low load strobe, then locks out the keypad.
module time_entry_loader #(
    parameter int               MAX_DIGITS   = 4,
    parameter logic [3:0]       SEC_TENS_MAX = timer_pkg::SEC_TENS_MAX,
    parameter int               LOAD_CYCLES  = 1
) (
    input  logic              clock,
    input  logic              clrn,
    input  logic              key_valid,
    input  logic [3:0]        key_digit,
    input  logic              start,
    input  logic              cancel,
    input  logic              timer_done,
    output logic [3:0]        min_tens,
    output logic [3:0]        min_ones,
    output logic [3:0]        sec_tens,
    output logic [3:0]        sec_ones,
    output logic              loadn,
    output logic              timer_en,
    output logic [2:0]        digit_count,
    output logic              entry_error,
    output timer_pkg::state_t fsm_state
);
    import timer_pkg::*;

    localparam logic [2:0] LOAD_LAST = 3'(LOAD_CYCLES - 1);

    state_t     state;
    logic [2:0] load_left;
    logic       accept;
    logic       clear;
    logic       bad_secs;
    logic       all_zero;

    // Priority cancel > start > key: a key arriving with either strobe is dropped.
    assign accept   = key_valid && !start && !cancel
                      && (state == IDLE || state == ENTRY)
                      && (key_digit <= BCD_MAX)
                      && (digit_count < 3'(MAX_DIGITS));
    assign clear    = cancel || (state == RUN && timer_done);
    assign bad_secs = sec_tens > SEC_TENS_MAX;
    assign all_zero = {min_tens, min_ones, sec_tens, sec_ones} == 16'd0;
    assign fsm_state = state;

    bcd_shift4 #(.MAX_DIGITS(MAX_DIGITS)) u_shift (
        .clock    (clock),
        .clrn     (clrn),
        .clear    (clear),
        .shift    (accept),
        .digit_in (key_digit),
        .d3       (min_tens),
        .d2       (min_ones),
        .d1       (sec_tens),
        .d0       (sec_ones),
        .count    (digit_count)
    );

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            state       <= IDLE;
            load_left   <= '0;
            loadn       <= 1'b1;
            timer_en    <= 1'b0;
            entry_error <= 1'b0;
        end else begin
            entry_error <= 1'b0;
            if (cancel) begin
                state    <= IDLE;
                loadn    <= 1'b1;
                timer_en <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept)
                            state <= ENTRY;
                    end
                    ENTRY: begin
                        if (start) begin
                            if (bad_secs || all_zero) begin
                                entry_error <= 1'b1;
                            end else begin
                                state     <= LOAD;
                                loadn     <= 1'b0;
                                load_left <= LOAD_LAST;
                            end
                        end
                    end
                    LOAD: begin
                        if (load_left == 3'd0) begin
                            state    <= RUN;
                            loadn    <= 1'b1;
                            timer_en <= 1'b1;
                        end else begin
                            load_left <= load_left - 3'd1;
                        end
                    end
                    RUN: begin
                        if (timer_done) begin
                            state    <= IDLE;
                            timer_en <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_time_entry_loader.sv
// Bench for time_entry_loader: directed vector table, random stimulus against a
// number-level reference model, and a LOAD_CYCLES=3 reset-during-load sequence.
module tb_time_entry_loader;
    import timer_pkg::*;

    logic       clock = 1'b0;
    logic       clrn  = 1'b0;
    logic       clrn3 = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_digit = 4'd0;
    logic       start = 1'b0;
    logic       cancel = 1'b0;
    logic       timer_done = 1'b0;

    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       loadn, timer_en, entry_error;
    logic [2:0] digit_count;
    state_t     fsm_state;

    logic [3:0] min_tens3, min_ones3, sec_tens3, sec_ones3;
    logic       loadn3, timer_en3, entry_error3;
    logic [2:0] digit_count3;
    state_t     fsm_state3;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    time_entry_loader #(.LOAD_CYCLES(1)) dut (
        .clock(clock), .clrn(clrn), .key_valid(key_valid), .key_digit(key_digit),
        .start(start), .cancel(cancel), .timer_done(timer_done),
        .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .loadn(loadn), .timer_en(timer_en), .digit_count(digit_count),
        .entry_error(entry_error), .fsm_state(fsm_state)
    );

    time_entry_loader #(.LOAD_CYCLES(3)) dut3 (
        .clock(clock), .clrn(clrn3), .key_valid(key_valid), .key_digit(key_digit),
        .start(start), .cancel(cancel), .timer_done(timer_done),
        .min_tens(min_tens3), .min_ones(min_ones3), .sec_tens(sec_tens3), .sec_ones(sec_ones3),
        .loadn(loadn3), .timer_en(timer_en3), .digit_count(digit_count3),
        .entry_error(entry_error3), .fsm_state(fsm_state3)
    );

    // Reference model: the entry is held as a decimal number MMSS.
    localparam int P_IDLE = 0, P_ENTRY = 1, P_LOAD = 2, P_RUN = 3;
    int m_num = 0, m_cnt = 0, m_phase = P_IDLE, m_left = 0;
    bit m_err = 0;

    task automatic model_step(input bit kv, input int kd, input bit st, input bit ca, input bit td);
        m_err = 0;
        if (ca) begin
            m_num = 0; m_cnt = 0; m_phase = P_IDLE;
        end else if (m_phase == P_IDLE || m_phase == P_ENTRY) begin
            if (st) begin
                if (m_phase == P_ENTRY) begin
                    if (((m_num / 10) % 10) > 5 || m_num == 0) m_err = 1;
                    else begin m_phase = P_LOAD; m_left = 1; end
                end
            end else if (kv && kd <= 9 && m_cnt < 4) begin
                m_num = (m_num * 10 + kd) % 10000;
                m_cnt++;
                m_phase = P_ENTRY;
            end
        end else if (m_phase == P_LOAD) begin
            m_left--;
            if (m_left == 0) m_phase = P_RUN;
        end else if (td) begin
            m_num = 0; m_cnt = 0; m_phase = P_IDLE;
        end
    endtask

    function automatic logic [15:0] num_digits(input int n);
        return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    function automatic state_t phase_state(input int p);
        case (p)
            P_ENTRY: return ENTRY;
            P_LOAD:  return LOAD;
            P_RUN:   return RUN;
            default: return IDLE;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_digits"}, int'({min_tens, min_ones, sec_tens, sec_ones}), int'(num_digits(m_num)));
        chk({tag, "_count"}, int'(digit_count), m_cnt);
        chk({tag, "_loadn"}, int'(loadn), int'(m_phase != P_LOAD));
        chk({tag, "_timer_en"}, int'(timer_en), int'(m_phase == P_RUN));
        chk({tag, "_error"}, int'(entry_error), int'(m_err));
        chk({tag, "_state"}, int'(fsm_state), int'(phase_state(m_phase)));
    endtask

    // One clock: drive inputs, step the model on the edge, sample 1ns later.
    task automatic cycle(input bit kv, input logic [3:0] kd, input bit st, input bit ca, input bit td,
                         input string tag);
        key_valid = kv; key_digit = kd; start = st; cancel = ca; timer_done = td;
        @(posedge clock);
        model_step(kv, int'(kd), st, ca, td);
        #1;
        check_model(tag);
    endtask

    typedef struct {
        bit         kv;
        logic [3:0] kd;
        bit         st, ca, td;
        logic [15:0] dig;
        int         cnt;
        bit         ln, en, err;
        state_t     s;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit kv, input logic [3:0] kd, input bit st, input bit ca, input bit td,
                       input logic [15:0] dig, input int cnt, input bit ln, input bit en,
                       input bit err, input state_t s);
        vec_t v;
        v.kv = kv; v.kd = kd; v.st = st; v.ca = ca; v.td = td;
        v.dig = dig; v.cnt = cnt; v.ln = ln; v.en = en; v.err = err; v.s = s;
        vecs.push_back(v);
    endtask

    initial begin
        int low_cnt;

        //  kv kd    st ca td   digits   cnt ln en err state
        add(1, 4'h1, 0, 0, 0, 16'h0001, 1, 1, 0, 0, ENTRY);
        add(1, 4'h2, 0, 0, 0, 16'h0012, 2, 1, 0, 0, ENTRY);
        add(1, 4'h3, 0, 0, 0, 16'h0123, 3, 1, 0, 0, ENTRY);
        add(0, 4'h0, 1, 0, 0, 16'h0123, 3, 0, 0, 0, LOAD);
        add(0, 4'h0, 0, 0, 0, 16'h0123, 3, 1, 1, 0, RUN);
        add(0, 4'h0, 0, 0, 0, 16'h0123, 3, 1, 1, 0, RUN);
        add(1, 4'h7, 1, 0, 0, 16'h0123, 3, 1, 1, 0, RUN);
        add(0, 4'h0, 0, 0, 1, 16'h0000, 0, 1, 0, 0, IDLE);
        add(0, 4'h0, 1, 0, 0, 16'h0000, 0, 1, 0, 0, IDLE);
        add(1, 4'hF, 0, 0, 0, 16'h0000, 0, 1, 0, 0, IDLE);
        add(1, 4'h9, 0, 0, 0, 16'h0009, 1, 1, 0, 0, ENTRY);
        add(1, 4'h9, 0, 0, 0, 16'h0099, 2, 1, 0, 0, ENTRY);
        add(1, 4'h9, 0, 0, 0, 16'h0999, 3, 1, 0, 0, ENTRY);
        add(1, 4'h9, 0, 0, 0, 16'h9999, 4, 1, 0, 0, ENTRY);
        add(1, 4'h8, 0, 0, 0, 16'h9999, 4, 1, 0, 0, ENTRY);
        add(0, 4'h0, 1, 0, 0, 16'h9999, 4, 1, 0, 1, ENTRY);
        add(0, 4'h0, 0, 0, 0, 16'h9999, 4, 1, 0, 0, ENTRY);
        add(0, 4'h0, 0, 1, 0, 16'h0000, 0, 1, 0, 0, IDLE);
        add(1, 4'h0, 0, 0, 0, 16'h0000, 1, 1, 0, 0, ENTRY);
        add(0, 4'h0, 1, 0, 0, 16'h0000, 1, 1, 0, 1, ENTRY);
        add(1, 4'hA, 0, 0, 0, 16'h0000, 1, 1, 0, 0, ENTRY);
        add(1, 4'h5, 0, 0, 0, 16'h0005, 2, 1, 0, 0, ENTRY);
        add(0, 4'h0, 0, 1, 0, 16'h0000, 0, 1, 0, 0, IDLE);
        add(1, 4'h4, 0, 0, 0, 16'h0004, 1, 1, 0, 0, ENTRY);
        add(1, 4'h5, 0, 0, 0, 16'h0045, 2, 1, 0, 0, ENTRY);
        add(0, 4'h0, 1, 0, 0, 16'h0045, 2, 0, 0, 0, LOAD);
        add(0, 4'h0, 0, 0, 0, 16'h0045, 2, 1, 1, 0, RUN);
        add(1, 4'h7, 1, 0, 0, 16'h0045, 2, 1, 1, 0, RUN);
        add(0, 4'h0, 0, 0, 1, 16'h0000, 0, 1, 0, 0, IDLE);
        add(1, 4'h1, 0, 0, 1, 16'h0001, 1, 1, 0, 0, ENTRY);
        add(1, 4'h2, 0, 0, 0, 16'h0012, 2, 1, 0, 0, ENTRY);
        add(1, 4'h3, 1, 1, 0, 16'h0000, 0, 1, 0, 0, IDLE);
        add(0, 4'h0, 0, 0, 0, 16'h0000, 0, 1, 0, 0, IDLE);
        add(1, 4'h1, 0, 0, 0, 16'h0001, 1, 1, 0, 0, ENTRY);
        add(1, 4'h7, 1, 0, 0, 16'h0001, 1, 0, 0, 0, LOAD);
        add(0, 4'h0, 0, 0, 0, 16'h0001, 1, 1, 1, 0, RUN);
        add(0, 4'h0, 0, 1, 0, 16'h0000, 0, 1, 0, 0, IDLE);
        add(1, 4'h3, 0, 0, 0, 16'h0003, 1, 1, 0, 0, ENTRY);
        add(0, 4'h0, 1, 0, 0, 16'h0003, 1, 0, 0, 0, LOAD);
        add(0, 4'h0, 0, 1, 0, 16'h0000, 0, 1, 0, 0, IDLE);
        add(1, 4'h5, 0, 0, 0, 16'h0005, 1, 1, 0, 0, ENTRY);
        add(1, 4'h9, 0, 0, 0, 16'h0059, 2, 1, 0, 0, ENTRY);
        add(0, 4'h0, 1, 0, 0, 16'h0059, 2, 0, 0, 0, LOAD);
        add(0, 4'h0, 0, 0, 0, 16'h0059, 2, 1, 1, 0, RUN);
        add(0, 4'h0, 0, 0, 1, 16'h0000, 0, 1, 0, 0, IDLE);
        add(1, 4'h6, 0, 0, 0, 16'h0006, 1, 1, 0, 0, ENTRY);
        add(1, 4'h0, 0, 0, 0, 16'h0060, 2, 1, 0, 0, ENTRY);
        add(0, 4'h0, 1, 0, 0, 16'h0060, 2, 1, 0, 1, ENTRY);
        add(0, 4'h0, 0, 1, 0, 16'h0000, 0, 1, 0, 0, IDLE);

        // Reset state of both instances while clrn is held low.
        #12;
        chk("reset_digits", int'({min_tens, min_ones, sec_tens, sec_ones}), 0);
        chk("reset_count", int'(digit_count), 0);
        chk("reset_loadn", int'(loadn), 1);
        chk("reset_timer_en", int'(timer_en), 0);
        chk("reset_error", int'(entry_error), 0);
        chk("reset_state", int'(fsm_state), int'(IDLE));
        chk("reset3_loadn", int'(loadn3), 1);
        @(negedge clock);
        clrn = 1'b1;
        clrn3 = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            tag = $sformatf("row%0d", i);
            cycle(vecs[i].kv, vecs[i].kd, vecs[i].st, vecs[i].ca, vecs[i].td, tag);
            chk({tag, "_tbl_digits"}, int'({min_tens, min_ones, sec_tens, sec_ones}), int'(vecs[i].dig));
            chk({tag, "_tbl_count"}, int'(digit_count), vecs[i].cnt);
            chk({tag, "_tbl_loadn"}, int'(loadn), int'(vecs[i].ln));
            chk({tag, "_tbl_timer_en"}, int'(timer_en), int'(vecs[i].en));
            chk({tag, "_tbl_error"}, int'(entry_error), int'(vecs[i].err));
            chk({tag, "_tbl_state"}, int'(fsm_state), int'(vecs[i].s));
        end

        for (int i = 0; i < 3000; i++) begin
            bit kv, st, ca, td;
            logic [3:0] kd;
            kv = ($urandom_range(0, 99) < 50);
            kd = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(10, 15));
            st = ($urandom_range(0, 99) < 12);
            ca = ($urandom_range(0, 99) < 3);
            td = ($urandom_range(0, 99) < 10);
            cycle(kv, kd, st, ca, td, $sformatf("rnd%0d", i));
        end

        // LOAD_CYCLES=3 instance: full load window length.
        cycle(0, 4'h0, 0, 1, 0, "l3_clear");
        cycle(1, 4'h1, 0, 0, 0, "l3_k1");
        cycle(1, 4'h2, 0, 0, 0, "l3_k2");
        cycle(0, 4'h0, 1, 0, 0, "l3_start");
        low_cnt = (loadn3 == 1'b0) ? 1 : 0;
        for (int i = 0; i < 5; i++) begin
            cycle(0, 4'h0, 0, 0, 0, "l3_wait");
            if (loadn3 == 1'b0) low_cnt++;
        end
        chk("l3_low_cycles", low_cnt, 3);
        chk("l3_timer_en", int'(timer_en3), 1);
        chk("l3_digits", int'({min_tens3, min_ones3, sec_tens3, sec_ones3}), 16'h0012);

        // Async reset during the second low cycle of the load window.
        cycle(0, 4'h0, 0, 1, 0, "l3_clear2");
        cycle(1, 4'h4, 0, 0, 0, "l3_k4");
        cycle(0, 4'h0, 1, 0, 0, "l3_start2");
        chk("l3_low1", int'(loadn3), 0);
        cycle(0, 4'h0, 0, 0, 0, "l3_low2");
        chk("l3_low2", int'(loadn3), 0);
        clrn3 = 1'b0;
        #1;
        chk("l3_rst_loadn", int'(loadn3), 1);
        chk("l3_rst_digits", int'({min_tens3, min_ones3, sec_tens3, sec_ones3}), 0);
        chk("l3_rst_count", int'(digit_count3), 0);
        chk("l3_rst_timer_en", int'(timer_en3), 0);
        chk("l3_rst_error", int'(entry_error3), 0);
        @(negedge clock);
        clrn3 = 1'b1;
        cycle(0, 4'h0, 0, 0, 0, "l3_after1");
        cycle(0, 4'h0, 0, 0, 0, "l3_after2");
        chk("l3_after_state", int'(fsm_state3), int'(IDLE));
        chk("l3_after_loadn", int'(loadn3), 1);
        chk("l3_after_timer_en", int'(timer_en3), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
